pulse_toggle_tx: RTL and testbench
==================================

# pulse_toggle_tx

Write-domain front end for the toggle pulse-synchronizer path. It converts single-cycle events on `wr_clk` into level toggles on `req_tgl` for the downstream toggle synchronizer. It holds each toggle until the read domain returns a matching acknowledge toggle. Events arriving while a transfer is in flight are queued in a pending counter, so no event is lost up to the counter limit.

## Interface
- `PEND_W`, default 4: width of pending-event counter; maximum queued events = 2^PEND_W − 1.
- `ACK_SYNC_STAGES`, default 2: flop stages synchronizing `ack_tgl` into `wr_clk`; legal range ≥ 2.
- `wr_clk` in 1: write-domain clock.
- `wr_reset` in 1: reset, asynchronous, active-low; clock `wr_clk`.
- `evt_pulse` in 1: one event per asserted cycle.
- `ack_tgl` in 1: acknowledge toggle from the read domain, asynchronous to `wr_clk`. It equals the last `req_tgl` value the read side has consumed.
- `ovf_clr` in 1: clears sticky `overflow`.
- `req_tgl` out 1: request toggle level; feeds the toggle synchronizer data input.
- `busy` out 1: transfer in flight or events pending.
- `pend_cnt` out PEND_W: queued events not yet launched.
- `overflow` out 1: sticky; an event was lost.

## Operation
- `ack_tgl` passes through `ACK_SYNC_STAGES` flops, giving `ack_s`. All sync flops reset to 0.
- FSM states:
  - IDLE: no transfer in flight.
  - WAIT_ACK: `req_tgl` has been flipped; waiting for `ack_s == req_tgl`.
- IDLE:
  - If `evt_pulse` or `pend_cnt != 0`: flip `req_tgl` and go to WAIT_ACK.
  - If the launch consumed a pending event, `pend_cnt` decrements.
  - If the launch used `evt_pulse` and `pend_cnt != 0`, the event is queued instead. The net counter change is 0: the oldest pending event launches and the new one is queued.
- WAIT_ACK:
  - `evt_pulse` increments `pend_cnt`.
  - When `ack_s == req_tgl`, go to IDLE. No launch happens in that same cycle.
- Saturation:
  - `evt_pulse` with `pend_cnt` = all-ones in WAIT_ACK: counter holds, event dropped, `overflow` ← 1.
  - Same in IDLE: the launch decrements, so nothing is lost.
- Simultaneous events:
  - Ack and `evt_pulse` in the same cycle: `pend_cnt` increments and the FSM goes to IDLE.
  - `overflow` set and `ovf_clr` in the same cycle: set wins.
- `busy` = (state == WAIT_ACK) | (`pend_cnt != 0`). It is a combinational decode of registers.
- Reset mid-transfer:
  - All state clears: IDLE, `req_tgl` 0, `pend_cnt` 0, `overflow` 0.
  - In-flight and pending events are discarded.
  - The read side must be reset together with this block so that `ack_tgl` returns to 0.

## Timing
- Reset values: `req_tgl` 0, `busy` 0, `pend_cnt` 0, `overflow` 0, FSM IDLE.
- Launch latency: `evt_pulse` high in IDLE at edge N → `req_tgl` flips after edge N. `busy` is high in the following cycle.
- Ack latency: the change on `ack_tgl` reaches `ack_s` after `ACK_SYNC_STAGES` `wr_clk` edges. The FSM leaves WAIT_ACK on the next edge.
- Back-to-back: the next launch happens one cycle after returning to IDLE.
  - Minimum launch spacing = 2 + `ACK_SYNC_STAGES` `wr_clk` cycles plus the read-side round trip.
- `pend_cnt` and `overflow` update on the edge following the qualifying input.

## Configuration
- `PULSE_TX_PEND_EN` defined:
  - The pending counter is present, as described above.
- `PULSE_TX_PEND_EN` undefined:
  - No counter; `pend_cnt` is tied to 0.
  - `evt_pulse` during WAIT_ACK is dropped and sets `overflow`.
  - `evt_pulse` in IDLE launches as normal.
  - The ack and `evt_pulse` same-cycle case drops the event and sets `overflow`.

## Structure
- Shared package `cdc_pkg` holds:
  - `tx_state_e` enum (IDLE, WAIT_ACK).
  - Constant `CDC_SYNC_STAGES_DEF` = 2, used as the default for `ACK_SYNC_STAGES`.
- Sub-module `cdc_sync_bit`: parameterized N-stage bit synchronizer with async active-low reset. It is used for the `ack_tgl` path and is reusable elsewhere.

## Test plan
- Reset release with `ack_tgl`=0:
  - All outputs 0, FSM IDLE.
  - Assert `wr_reset` low mid-WAIT_ACK with `pend_cnt`=3 → outputs 0 on the same cycle.
- Single `evt_pulse`:
  - `req_tgl` 0→1 one cycle later; `busy`=1.
  - Drive `ack_tgl`=1 → `busy`=0 after 2 sync edges plus 1 cycle.
- Five pulses during WAIT_ACK:
  - `pend_cnt`=5.
  - Each ack launches the next; exactly 5 further `req_tgl` flips; `pend_cnt` ends at 0.
- `PEND_W`=2, five pulses in WAIT_ACK:
  - `pend_cnt` saturates at 3; `overflow`=1.
  - `ovf_clr` → 0; `ovf_clr` with a simultaneous overflow → stays 1.
- Ack and `evt_pulse` in the same cycle:
  - `pend_cnt` +1, FSM IDLE, launch on the next cycle.
- Build without `PULSE_TX_PEND_EN`:
  - Pulse during WAIT_ACK → `overflow`=1, `pend_cnt`=0, no extra `req_tgl` flip.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared CDC definitions: transmit FSM state encoding and the default
// synchronizer depth used by the toggle pulse-synchronizer blocks.
package cdc_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } tx_state_e;

    localparam int CDC_SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/pulse_toggle_tx_if.sv
// Handshake bundle between an event source / read-side acknowledge and the
// write-domain toggle transmitter. The slave modport is the transmitter.
interface pulse_toggle_tx_if #(
    parameter int PEND_W = 4
);

    logic              evt_pulse;
    logic              ack_tgl;
    logic              ovf_clr;
    logic              req_tgl;
    logic              busy;
    logic [PEND_W-1:0] pend_cnt;
    logic              overflow;

    modport master (
        output evt_pulse,
        output ack_tgl,
        output ovf_clr,
        input  req_tgl,
        input  busy,
        input  pend_cnt,
        input  overflow
    );

    modport slave (
        input  evt_pulse,
        input  ack_tgl,
        input  ovf_clr,
        output req_tgl,
        output busy,
        output pend_cnt,
        output overflow
    );

endinterface

// File: rtl/cdc_sync_bit.sv
// N-stage single-bit synchronizer with asynchronous active-low reset.
// All flops clear to 0 on reset; the output is the last stage.
module cdc_sync_bit
    import cdc_pkg::*;
#(
    parameter int STAGES = CDC_SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the synchronizer chain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_toggle_tx.sv
// Write-domain front end of the toggle pulse synchronizer. Each event pulse
// becomes a flip of req_tgl, held until the synchronized acknowledge toggle
// matches. Optional macro PULSE_TX_PEND_EN adds a saturating pending-event
// counter; without it, events arriving during a transfer are dropped and
// flagged in the sticky overflow bit.
module pulse_toggle_tx
    import cdc_pkg::*;
#(
    parameter int PEND_W          = 4,
    parameter int ACK_SYNC_STAGES = CDC_SYNC_STAGES_DEF
) (
    input  logic              wr_clk,
    input  logic              wr_reset,
    pulse_toggle_tx_if.slave  bus
);

    tx_state_e         state;
    tx_state_e         next_state;
    logic              ack_s;
    logic              req_q;
    logic              req_next;
    logic              ovf_q;
    logic              ovf_next;
    logic              ovf_set;
    logic [PEND_W-1:0] pend_q;
    logic              pend_nz;
    logic              ack_match;
    logic              launch;

    cdc_sync_bit #(
        .STAGES (ACK_SYNC_STAGES)
    ) u_ack_sync (
        .clk   (wr_clk),
        .reset (wr_reset),
        .d     (bus.ack_tgl),
        .q     (ack_s)
    );

    assign pend_nz   = (pend_q != '0);
    assign ack_match = (ack_s == req_q);
    assign launch    = (state == IDLE) && (bus.evt_pulse || pend_nz);

    // FSM state register
    always_ff @(posedge wr_clk or negedge wr_reset) begin
        if (!wr_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: launch from IDLE, return once the ack toggle catches up
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (launch)    next_state = WAIT_ACK;
            WAIT_ACK: if (ack_match) next_state = IDLE;
            default:                 next_state = IDLE;
        endcase
    end

`ifdef PULSE_TX_PEND_EN
    logic [PEND_W-1:0] pend_next;
    logic              pend_full;

    assign pend_full = &pend_q;

    // Output/datapath decode: toggle on launch, queue or drop events in flight
    always_comb begin
        req_next  = req_q;
        pend_next = pend_q;
        ovf_set   = 1'b0;
        case (state)
            IDLE: begin
                if (launch) begin
                    req_next = ~req_q;
                    if (pend_nz && !bus.evt_pulse) begin
                        pend_next = pend_q - 1'b1;
                    end
                end
            end
            WAIT_ACK: begin
                if (bus.evt_pulse) begin
                    if (pend_full) begin
                        ovf_set = 1'b1;
                    end else begin
                        pend_next = pend_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Pending-event counter register
    always_ff @(posedge wr_clk or negedge wr_reset) begin
        if (!wr_reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_next;
        end
    end
`else
    // Output/datapath decode: toggle on launch, drop any event while in flight
    always_comb begin
        req_next = req_q;
        ovf_set  = 1'b0;
        case (state)
            IDLE:     if (launch)        req_next = ~req_q;
            WAIT_ACK: if (bus.evt_pulse) ovf_set  = 1'b1;
            default: ;
        endcase
    end

    assign pend_q = '0;
`endif

    // A new loss takes priority over a clear request in the same cycle
    assign ovf_next = ovf_set | (ovf_q & ~bus.ovf_clr);

    // Request toggle and sticky overflow registers
    always_ff @(posedge wr_clk or negedge wr_reset) begin
        if (!wr_reset) begin
            req_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            req_q <= req_next;
            ovf_q <= ovf_next;
        end
    end

    assign bus.req_tgl  = req_q;
    assign bus.busy     = (state == WAIT_ACK) | pend_nz;
    assign bus.pend_cnt = pend_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_pulse_toggle_tx.sv
// Directed bench for pulse_toggle_tx. dut_a (PEND_W=4) drives a scoreboard of
// expected req_tgl flips; dut_b (PEND_W=2) exercises saturation and overflow.
// Expectations adapt to whether PULSE_TX_PEND_EN is defined.
module tb_pulse_toggle_tx;
    import cdc_pkg::*;

    logic wr_clk   = 1'b0;
    logic wr_reset = 1'b0;

    int   vec_count  = 0;
    int   miscompares = 0;

    logic model_req  = 1'b0;
    logic last_req_a = 1'b0;
    logic exp_q[$];

    pulse_toggle_tx_if #(.PEND_W(4)) bus_a ();
    pulse_toggle_tx_if #(.PEND_W(2)) bus_b ();

    pulse_toggle_tx #(.PEND_W(4), .ACK_SYNC_STAGES(2)) dut_a (
        .wr_clk   (wr_clk),
        .wr_reset (wr_reset),
        .bus      (bus_a)
    );

    pulse_toggle_tx #(.PEND_W(2), .ACK_SYNC_STAGES(2)) dut_b (
        .wr_clk   (wr_clk),
        .wr_reset (wr_reset),
        .bus      (bus_b)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic tick(input int n);
        repeat (n) @(negedge wr_clk);
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vec_count++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic push_a();
        model_req = ~model_req;
        exp_q.push_back(model_req);
    endtask

    // Acknowledge every request of dut_a until it is idle, bounded
    task automatic drain_a(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge wr_clk);
            if (!bus_a.busy) done = 1'b1;
            else bus_a.ack_tgl = bus_a.req_tgl;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    // Scoreboard: every observed req_tgl flip of dut_a must match the queue head
    always @(negedge wr_clk) begin
        if (!wr_reset) begin
            last_req_a = 1'b0;
        end else if (bus_a.req_tgl !== last_req_a) begin
            last_req_a = bus_a.req_tgl;
            if (exp_q.size() == 0) begin
                vec_count++;
                miscompares++;
                $error("[TB] FAIL req_flip_unexpected observed=%0b expected=no flip", bus_a.req_tgl);
            end else begin
                check("req_flip", 32'(bus_a.req_tgl), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        bus_a.evt_pulse = 1'b0; bus_a.ack_tgl = 1'b0; bus_a.ovf_clr = 1'b0;
        bus_b.evt_pulse = 1'b0; bus_b.ack_tgl = 1'b0; bus_b.ovf_clr = 1'b0;
        tick(3);
        wr_reset = 1'b1;
        tick(2);

        // Reset state
        check("rst_req",   32'(bus_a.req_tgl),  32'd0);
        check("rst_busy",  32'(bus_a.busy),     32'd0);
        check("rst_pend",  32'(bus_a.pend_cnt), 32'd0);
        check("rst_ovf",   32'(bus_a.overflow), 32'd0);
        check("rst_state", 32'(dut_a.state),    32'(IDLE));

        // Single event: launch, then ack after two sync edges plus one cycle
        bus_a.evt_pulse = 1'b1; push_a(); tick(1); bus_a.evt_pulse = 1'b0;
        check("single_req",  32'(bus_a.req_tgl), 32'd1);
        check("single_busy", 32'(bus_a.busy),    32'd1);
        bus_a.ack_tgl = 1'b1;
        tick(2);
        check("single_busy_sync", 32'(bus_a.busy), 32'd1);
        tick(1);
        check("single_busy_release", 32'(bus_a.busy), 32'd0);
        check("single_state_idle",   32'(dut_a.state), 32'(IDLE));

        // Launch plus five events in WAIT_ACK
        bus_a.evt_pulse = 1'b1; push_a(); tick(6); bus_a.evt_pulse = 1'b0;
`ifdef PULSE_TX_PEND_EN
        check("five_pend", 32'(bus_a.pend_cnt), 32'd5);
        check("five_ovf",  32'(bus_a.overflow), 32'd0);
        repeat (5) push_a();
`else
        check("five_pend", 32'(bus_a.pend_cnt), 32'd0);
        check("five_ovf",  32'(bus_a.overflow), 32'd1);
`endif
        drain_a("five_drain_timeout");
        check("five_pend_end", 32'(bus_a.pend_cnt), 32'd0);
        check("five_busy_end", 32'(bus_a.busy), 32'd0);
        check("five_sb_empty", 32'(exp_q.size()), 32'd0);
        bus_a.ovf_clr = 1'b1; tick(1); bus_a.ovf_clr = 1'b0;
        check("five_ovf_clr", 32'(bus_a.overflow), 32'd0);

        // Ack and event in the same cycle
        bus_a.evt_pulse = 1'b1; push_a(); tick(1); bus_a.evt_pulse = 1'b0;
        bus_a.ack_tgl = model_req;
        tick(2);
        bus_a.evt_pulse = 1'b1;
`ifdef PULSE_TX_PEND_EN
        push_a();
`endif
        tick(1);
        bus_a.evt_pulse = 1'b0;
        check("same_state_idle", 32'(dut_a.state), 32'(IDLE));
`ifdef PULSE_TX_PEND_EN
        check("same_pend", 32'(bus_a.pend_cnt), 32'd1);
        check("same_busy", 32'(bus_a.busy),     32'd1);
        check("same_ovf",  32'(bus_a.overflow), 32'd0);
        tick(1);
        check("same_state_launch", 32'(dut_a.state),    32'(WAIT_ACK));
        check("same_pend_launch",  32'(bus_a.pend_cnt), 32'd0);
`else
        check("same_pend", 32'(bus_a.pend_cnt), 32'd0);
        check("same_busy", 32'(bus_a.busy),     32'd0);
        check("same_ovf",  32'(bus_a.overflow), 32'd1);
        tick(1);
        check("same_state_launch", 32'(dut_a.state), 32'(IDLE));
`endif
        check("same_req", 32'(bus_a.req_tgl), 32'(model_req));
        drain_a("same_drain_timeout");
        check("same_sb_empty", 32'(exp_q.size()), 32'd0);
        bus_a.ovf_clr = 1'b1; tick(1); bus_a.ovf_clr = 1'b0;

        // Reset asserted mid-transfer with events pending
        bus_a.evt_pulse = 1'b1; push_a(); tick(4); bus_a.evt_pulse = 1'b0;
`ifdef PULSE_TX_PEND_EN
        check("mid_pend", 32'(bus_a.pend_cnt), 32'd3);
`else
        check("mid_ovf",  32'(bus_a.overflow), 32'd1);
`endif
        check("mid_busy", 32'(bus_a.busy), 32'd1);
        check("mid_sb_empty", 32'(exp_q.size()), 32'd0);
        #2;
        wr_reset = 1'b0;
        bus_a.ack_tgl = 1'b0;
        bus_b.ack_tgl = 1'b0;
        #1;
        check("mid_rst_req",   32'(bus_a.req_tgl),  32'd0);
        check("mid_rst_busy",  32'(bus_a.busy),     32'd0);
        check("mid_rst_pend",  32'(bus_a.pend_cnt), 32'd0);
        check("mid_rst_ovf",   32'(bus_a.overflow), 32'd0);
        check("mid_rst_state", 32'(dut_a.state),    32'(IDLE));
        model_req = 1'b0;
        tick(2);
        wr_reset = 1'b1;
        tick(1);

        // Saturation on the narrow instance, ack never returned
        bus_b.evt_pulse = 1'b1; tick(6); bus_b.evt_pulse = 1'b0;
        check("sat_req", 32'(bus_b.req_tgl), 32'd1);
`ifdef PULSE_TX_PEND_EN
        check("sat_pend", 32'(bus_b.pend_cnt), 32'd3);
`else
        check("sat_pend", 32'(bus_b.pend_cnt), 32'd0);
`endif
        check("sat_ovf", 32'(bus_b.overflow), 32'd1);
        bus_b.ovf_clr = 1'b1; tick(1); bus_b.ovf_clr = 1'b0;
        check("sat_ovf_clr", 32'(bus_b.overflow), 32'd0);
        bus_b.ovf_clr = 1'b1; bus_b.evt_pulse = 1'b1; tick(1);
        bus_b.ovf_clr = 1'b0; bus_b.evt_pulse = 1'b0;
        check("sat_ovf_set_wins", 32'(bus_b.overflow), 32'd1);
        check("sat_req_hold",     32'(bus_b.req_tgl),  32'd1);
`ifdef PULSE_TX_PEND_EN
        check("sat_pend_hold", 32'(bus_b.pend_cnt), 32'd3);
`endif

        tick(2);
        check("end_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
